// File: rtl/ram64_arb_pkg.sv
// Shared constants, state encoding and small helpers for the RAM64 two-port arbiter.
package ram64_arb_pkg;

  localparam int AW_DEF = 6;
  localparam int DW_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    ACC0 = ST_ACC0,
    ACC1 = ST_ACC1
  } arb_state_e;

  // Port currently owning the RAM; its req is still high until it sees ack.
  function automatic logic [1:0] owner_mask(input logic [1:0] st);
    return {st == ST_ACC1, st == ST_ACC0};
  endfunction

endpackage

// File: rtl/ram64_arb_pick.sv
// Two-way request picker: masks out the current owner, then round-robin or fixed priority.
// Purely combinational; no state of its own.
module ram64_arb_pick (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last,
  input  logic       i_fixed_prio,
  input  logic [1:0] i_excl,
  output logic       o_grant,
  output logic       o_vld
);

  logic w_r0;
  logic w_r1;

  assign w_r0  = i_req0 & ~i_excl[0];
  assign w_r1  = i_req1 & ~i_excl[1];
  assign o_vld = w_r0 | w_r1;

  // Under contention round-robin favours the port that was not served last.
  assign o_grant = (w_r0 & w_r1) ? (~i_fixed_prio & ~i_last) : w_r1;

endmodule

// File: rtl/ram64_arbiter.sv
// Shares one RAM64 between two requesters with single-cycle accesses; ack two edges after req.
// Requests are held until ack; a losing port waits one extra cycle, never starves.
module ram64_arbiter
  import ram64_arb_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DW         = DW_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_in,
  output logic          ram_load,
  input  logic [DW-1:0] ram_out
);

  logic [1:0]    r_state;
  logic          r_last;
  logic          r_ack0;
  logic          r_ack1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;

  logic [1:0]    w_excl;
  logic [1:0]    w_state_nxt;
  logic          w_grant;
  logic          w_vld;

  assign w_excl = owner_mask(r_state);

  ram64_arb_pick u_pick (
    .i_req0       (req0),
    .i_req1       (req1),
    .i_last       (r_last),
    .i_fixed_prio (FIXED_PRIO),
    .i_excl       (w_excl),
    .o_grant      (w_grant),
    .o_vld        (w_vld)
  );

  assign w_state_nxt = !w_vld ? ST_IDLE : (w_grant ? ST_ACC1 : ST_ACC0);

  // RAM drive follows state directly so an asynchronous reset drops load at once.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_load    = 1'b0;
    case (r_state)
      ST_ACC0: begin
        ram_address = addr0;
        ram_in      = wdata0;
        ram_load    = we0;
      end
      ST_ACC1: begin
        ram_address = addr1;
        ram_in      = wdata1;
        ram_load    = we1;
      end
      default: begin
        ram_address = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ack0  <= (r_state == ST_ACC0);
      r_ack1  <= (r_state == ST_ACC1);
      if (r_state == ST_ACC0) begin
        r_last <= 1'b0;
        if (!we0) r_rdata0 <= ram_out;
      end
      if (r_state == ST_ACC1) begin
        r_last <= 1'b1;
        if (!we1) r_rdata1 <= ram_out;
      end
    end
  end

  assign ack0   = r_ack0;
  assign ack1   = r_ack1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;

endmodule

// File: tb/tb_ram64_arbiter.sv
// Bench for ram64_arbiter: RAM64 model, queue-driven requesters, transaction-level scoreboard.
module tb_ram64_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [5:0]  addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic        ack0, ack1;
  logic [15:0] rdata0, rdata1;
  logic [5:0]  ram_address;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [15:0] ram_out;

  logic        f_req0, f_req1, f_we0, f_we1;
  logic [5:0]  f_addr0, f_addr1;
  logic [15:0] f_wd0, f_wd1;
  logic        f_ack0, f_ack1;
  logic [15:0] f_rdata0, f_rdata1;
  logic [5:0]  f_ram_address;
  logic [15:0] f_ram_in;
  logic        f_ram_load;
  logic [15:0] f_ram_out;

  ram64_arbiter #(.AW(6), .DW(16), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  ram64_arbiter #(.AW(6), .DW(16), .FIXED_PRIO(1'b1)) u_fp (
    .clk(clk), .reset(reset),
    .req0(f_req0), .req1(f_req1), .we0(f_we0), .we1(f_we1),
    .addr0(f_addr0), .addr1(f_addr1), .wdata0(f_wd0), .wdata1(f_wd1),
    .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1),
    .ram_address(f_ram_address), .ram_in(f_ram_in), .ram_load(f_ram_load), .ram_out(f_ram_out)
  );

  // RAM64 behaviour: synchronous write, combinational read
  logic [15:0] mem  [64] = '{default: 16'h0};
  logic [15:0] fmem [64] = '{default: 16'h0};
  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  always @(posedge clk) if (f_ram_load) fmem[f_ram_address] <= f_ram_in;
  assign ram_out   = mem[ram_address];
  assign f_ram_out = fmem[f_ram_address];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
    end
  endtask

  task automatic eq(input string nm, input logic [31:0] act, input logic [31:0] req);
    chk(nm, act === req, act, req);
  endtask

  typedef struct packed {
    logic        we;
    logic [5:0]  addr;
    logic [15:0] wd;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];

  task automatic push(input int p, input logic we, input logic [5:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.wd = d;
    if (p == 0) q0.push_back(t);
    else q1.push_back(t);
  endtask

  // Requesters: hold req until ack is seen, then drop it or present the next queued item.
  initial begin
    txn_t t;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        req0 = 1'b0;
        req1 = 1'b0;
        q0.delete();
        q1.delete();
      end else begin
        if (req0 && ack0) req0 = 1'b0;
        if (req1 && ack1) req1 = 1'b0;
        if (!req0 && q0.size() != 0) begin
          t = q0.pop_front();
          we0 = t.we; addr0 = t.addr; wdata0 = t.wd; req0 = 1'b1;
        end
        if (!req1 && q1.size() != 0) begin
          t = q1.pop_front();
          we1 = t.we; addr1 = t.addr; wdata1 = t.wd; req1 = 1'b1;
        end
      end
    end
  end

  // Reference model: accesses are serialised in ack order; each ack follows its own RAM cycle.
  logic [15:0] ref_mem [64] = '{default: 16'h0};
  logic [15:0] exp_rd0, exp_rd1;
  int          age0, age1;
  logic        p_vld, p_req0, p_req1, p_we0, p_we1, p_load;
  logic [5:0]  p_addr0, p_addr1, p_addr;
  logic [15:0] p_wd0, p_wd1, p_in;

  initial begin
    exp_rd0 = '0; exp_rd1 = '0; age0 = 0; age1 = 0; p_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        eq("rst_ack_load", 32'({ack0, ack1, ram_load}), 0);
        eq("rst_ram_addr_in", 32'({ram_address, ram_in}), 0);
        eq("rst_rdata", {rdata0, rdata1}, 0);
        exp_rd0 = '0; exp_rd1 = '0; age0 = 0; age1 = 0; p_vld = 1'b0;
      end else begin
        if (req0) age0++;
        if (req1) age1++;
        eq("ack_exclusive", 32'(ack0 & ack1), 0);
        if (ack0) begin
          eq("ack0_had_req", 32'(p_vld & p_req0), 1);
          eq("ack0_ram_access", 32'({p_load, p_addr, p_in}), 32'({p_we0, p_addr0, p_wd0}));
          chk("ack0_latency", age0 == 2 || age0 == 3, age0, 2);
          if (p_we0) ref_mem[p_addr0] = p_wd0;
          else exp_rd0 = ref_mem[p_addr0];
          age0 = 0;
        end
        if (ack1) begin
          eq("ack1_had_req", 32'(p_vld & p_req1), 1);
          eq("ack1_ram_access", 32'({p_load, p_addr, p_in}), 32'({p_we1, p_addr1, p_wd1}));
          chk("ack1_latency", age1 == 2 || age1 == 3, age1, 2);
          if (p_we1) ref_mem[p_addr1] = p_wd1;
          else exp_rd1 = ref_mem[p_addr1];
          age1 = 0;
        end
        if (!ack0 && !ack1 && p_vld)
          eq("idle_ram_drive", 32'({p_load, p_addr, p_in}), 0);
        eq("rdata0", 32'(rdata0), 32'(exp_rd0));
        eq("rdata1", 32'(rdata1), 32'(exp_rd1));
        chk("ack0_timeout", age0 <= 3, age0, 3);
        chk("ack1_timeout", age1 <= 3, age1, 3);
        if (age0 > 3) age0 = 0;
        if (age1 > 3) age1 = 0;
        p_vld = 1'b1;
        p_req0 = req0; p_we0 = we0; p_addr0 = addr0; p_wd0 = wdata0;
        p_req1 = req1; p_we1 = we1; p_addr1 = addr1; p_wd1 = wdata1;
        p_load = ram_load; p_addr = ram_address; p_in = ram_in;
      end
    end
  end

  logic        lg_ack0 [32];
  logic        lg_ack1 [32];
  logic        lg_load [32];
  logic [5:0]  lg_addr [32];
  logic [15:0] lg_in   [32];

  task automatic sync();
    @(posedge clk);
    #2;
  endtask

  // Cycle 0 is the negedge where queued requests get raised; cycle 1 is the first access.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      lg_ack0[c] = ack0; lg_ack1[c] = ack1; lg_load[c] = ram_load;
      lg_addr[c] = ram_address; lg_in[c] = ram_in;
    end
  endtask

  task automatic drain(input string nm);
    eq(nm, 32'({req0, req1}) + q0.size() + q1.size(), 0);
  endtask

  function automatic logic [31:0] acks(input int c);
    return 32'({lg_ack0[c], lg_ack1[c]});
  endfunction

  initial begin
    reset = 1'b1;
    f_req0 = 1'b0; f_req1 = 1'b0; f_we0 = 1'b0; f_we1 = 1'b0;
    f_addr0 = '0; f_addr1 = '0; f_wd0 = '0; f_wd1 = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    eq("init_ack_load_addr", 32'({ack0, ack1, ram_load, ram_address}), 0);
    eq("init_ram_in", 32'(ram_in), 0);
    eq("init_rdata", {rdata0, rdata1}, 0);

    // simultaneous writes: port 0 wins first contention after reset
    sync(); push(0, 1'b1, 6'd1, 16'h5555); push(1, 1'b1, 6'd2, 16'h1234);
    run(5); drain("simw_drain");
    eq("simw_acks_c2", acks(2), 32'b10);
    eq("simw_acks_c3", acks(3), 32'b01);
    eq("simw_access_c1", 32'({lg_load[1], lg_addr[1], lg_in[1]}), 32'({1'b1, 6'd1, 16'h5555}));
    eq("simw_access_c2", 32'({lg_load[2], lg_addr[2], lg_in[2]}), 32'({1'b1, 6'd2, 16'h1234}));

    sync(); push(0, 1'b0, 6'd1, 16'h0); push(1, 1'b0, 6'd2, 16'h0);
    run(5); drain("simr_drain");
    eq("simr_acks_c2", acks(2), 32'b10);
    eq("simr_rdata0", 32'(rdata0), 32'h5555);
    eq("simr_rdata1", 32'(rdata1), 32'h1234);

    // same-address race: port 1's read sees the write committed one cycle earlier
    sync(); push(0, 1'b1, 6'd63, 16'hBEEF); push(1, 1'b0, 6'd63, 16'h0);
    run(5); drain("race_drain");
    eq("race_acks_c3", acks(3), 32'b01);
    eq("race_rdata1", 32'(rdata1), 32'hBEEF);

    sync(); push(0, 1'b1, 6'd0, 16'hAAAA);
    run(4); drain("w0_drain");
    eq("w0_load_c0", 32'(lg_load[0]), 0);
    eq("w0_access_c1", 32'({lg_load[1], lg_addr[1], lg_in[1]}), 32'({1'b1, 6'd0, 16'hAAAA}));
    eq("w0_load_c2", 32'(lg_load[2]), 0);
    eq("w0_acks_c1", acks(1), 0);
    eq("w0_acks_c2", acks(2), 32'b10);
    eq("w0_acks_c3", acks(3), 0);

    sync(); push(0, 1'b0, 6'd0, 16'h0);
    run(4); drain("r0_drain");
    eq("r0_acks_c2", acks(2), 32'b10);
    eq("r0_load_c1", 32'(lg_load[1]), 0);
    eq("r0_rdata0", 32'(rdata0), 32'hAAAA);

    // port 0 was served last, so round-robin now favours port 1
    sync(); push(0, 1'b0, 6'd0, 16'h0); push(1, 1'b0, 6'd1, 16'h0);
    run(5); drain("rr_drain");
    eq("rr_acks_c2", acks(2), 32'b01);
    eq("rr_acks_c3", acks(3), 32'b10);
    eq("rr_rdata0", 32'(rdata0), 32'hAAAA);
    eq("rr_rdata1", 32'(rdata1), 32'h5555);

    sync();
    for (int i = 0; i < 8; i++) begin
      push(0, 1'b0, 6'(i), 16'h0F0F);
      push(1, 1'b0, 6'(8 + i), 16'hF0F0);
    end
    run(20); drain("fair_drain");
    for (int c = 0; c < 20; c++) begin
      if (c < 2 || c > 17) eq("fair_gap", acks(c), 0);
      else eq("fair_alternate", acks(c), (c % 2 == 0) ? 32'b01 : 32'b10);
    end

    // reset in the middle of a write access
    sync(); push(0, 1'b1, 6'd5, 16'hFFFF);
    @(negedge clk);
    @(posedge clk);
    #1;
    eq("rstmid_before", 32'({ram_load, ram_address, ram_in}), 32'({1'b1, 6'd5, 16'hFFFF}));
    #1 reset = 1'b1;
    #1;
    eq("rstmid_load_drop", 32'({ram_load, ram_address}), 0);
    eq("rstmid_in_drop", 32'(ram_in), 0);
    @(posedge clk);
    #2 reset = 1'b0;
    run(4);
    for (int c = 0; c < 4; c++) eq("rstmid_no_ack", acks(c), 0);
    sync(); push(0, 1'b0, 6'd5, 16'h0);
    run(4); drain("rstmid_drain");
    eq("rstmid_read_ack", acks(2), 32'b10);
    eq("rstmid_read5", 32'(rdata0), 0);

    sync();
    run(10);
    for (int c = 0; c < 10; c++)
      eq("idle_quiet", 32'({lg_ack0[c], lg_ack1[c], lg_load[c], lg_addr[c]}), 0);
    eq("idle_rdata", {rdata0, rdata1}, 0);

    // fixed-priority instance: port 0 wins even right after being served
    sync();
    @(negedge clk); #1;
    f_req0 = 1'b1; f_we0 = 1'b0; f_addr0 = 6'd3;
    @(negedge clk);
    eq("fp_c1_access", 32'({f_ram_load, f_ram_address}), 32'd3);
    @(negedge clk);
    eq("fp_c2_acks", 32'({f_ack0, f_ack1}), 32'b10);
    #1;
    f_addr0 = 6'd4; f_req1 = 1'b1; f_addr1 = 6'd5;
    @(negedge clk);
    eq("fp_contend_addr", 32'(f_ram_address), 32'd4);
    @(negedge clk);
    eq("fp_c4_acks", 32'({f_ack0, f_ack1}), 32'b10);
    eq("fp_c4_addr", 32'(f_ram_address), 32'd5);
    #1 f_req0 = 1'b0;
    @(negedge clk);
    eq("fp_c5_acks", 32'({f_ack0, f_ack1}), 32'b01);
    #1 f_req1 = 1'b0;
    @(negedge clk);
    eq("fp_c6_acks", 32'({f_ack0, f_ack1}), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
